// File: rtl/mx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mx_pkg
//  Purpose  : Shared constants, scan-state encoding and helpers for the
//             8x8 dot-matrix scan driver and its '595 serializer.
//  Ports    : (package - none)
//  Revision : 1.0  initial release
// ============================================================================
package mx_pkg;

    localparam int MX_ROWS    = 8;
    localparam int MX_COLS    = 8;
    localparam int MX_FRAME_W = 64;
    localparam int SR_BITS    = 16;

    typedef enum logic [2:0] {
        LOAD     = 3'd0,
        SHIFT_LO = 3'd1,
        SHIFT_HI = 3'd2,
        LATCH    = 3'd3,
        HOLD     = 3'd4
    } scan_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sr595_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : sr595_serializer
//  Purpose  : Loads a 16-bit word and clocks it MSB-first into two cascaded
//             74HC595s, then pulses the storage latch.
//  Ports    : clk, rst_n        - clock, async active-low reset
//             i_start, i_word   - start strobe (honoured only when idle), word
//             o_done            - high on the last LATCH cycle
//             o_sr_data/clk/latch - '595 SER / SRCLK / RCLK
//  Revision : 1.0  initial release
// ============================================================================
module sr595_serializer
    import mx_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int PHASE_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic [SR_BITS-1:0] i_word,
    output logic               o_done,
    output logic               o_sr_data,
    output logic               o_sr_clk,
    output logic               o_sr_latch
);

    localparam logic [PHASE_W-1:0] C_PH_RELOAD = PHASE_W'(CLK_DIV - 1);

    scan_state_t        r_state, w_state_nxt;
    logic [PHASE_W-1:0] r_phase, w_phase_nxt;
    logic [3:0]         r_bit,   w_bit_nxt;
    logic [SR_BITS-1:0] r_word,  w_word_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LOAD;
            r_phase <= '0;
            r_bit   <= '0;
            r_word  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_bit   <= w_bit_nxt;
            r_word  <= w_word_nxt;
        end
    end

    // LOAD doubles as the idle state; every phase entry reloads the divider.
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_bit_nxt   = r_bit;
        w_word_nxt  = r_word;
        o_done      = 1'b0;
        case (r_state)
            LOAD: begin
                if (i_start) begin
                    w_word_nxt  = i_word;
                    w_bit_nxt   = 4'd15;
                    w_phase_nxt = C_PH_RELOAD;
                    w_state_nxt = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (r_phase == '0) begin
                    w_phase_nxt = C_PH_RELOAD;
                    w_state_nxt = SHIFT_HI;
                end else begin
                    w_phase_nxt = r_phase - PHASE_W'(1);
                end
            end
            SHIFT_HI: begin
                if (r_phase == '0) begin
                    w_phase_nxt = C_PH_RELOAD;
                    if (r_bit == 4'd0) begin
                        w_state_nxt = LATCH;
                    end else begin
                        w_bit_nxt   = r_bit - 4'd1;
                        w_state_nxt = SHIFT_LO;
                    end
                end else begin
                    w_phase_nxt = r_phase - PHASE_W'(1);
                end
            end
            LATCH: begin
                if (r_phase == '0) begin
                    o_done      = 1'b1;
                    w_state_nxt = LOAD;
                end else begin
                    w_phase_nxt = r_phase - PHASE_W'(1);
                end
            end
            default: w_state_nxt = LOAD;
        endcase
    end

    // Pin outputs decode straight from registers so an async reset drops them at once.
    assign o_sr_clk   = (r_state == SHIFT_HI);
    assign o_sr_latch = (r_state == LATCH);
    assign o_sr_data  = ((r_state == SHIFT_LO) || (r_state == SHIFT_HI)) ? r_word[r_bit] : 1'b0;

endmodule
`default_nettype wire

// File: rtl/matrix_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : matrix_scan_driver
//  Purpose  : Double-buffered 8x8 frame store that row-scans the active frame
//             through two cascaded 74HC595s (far = row select, near = columns).
//  Ports    : clk, rst_n                - clock, async active-low reset
//             i_frame_in, i_frame_we    - frame (bit y*8+x) and write strobe
//             o_frame_pending           - shadow holds an undisplayed frame
//             o_frame_done              - pulse at end of row 7 dwell
//             o_sr_data/clk/latch/oe_n  - '595 SER / SRCLK / RCLK / OE_n
//  Revision : 1.0  initial release
// ============================================================================
module matrix_scan_driver
    import mx_pkg::*;
#(
    parameter int CLK_DIV        = 4,
    parameter int DWELL          = 2000,
    parameter int ROW_ACTIVE_LOW = 1,
    parameter int COL_ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [MX_FRAME_W-1:0] i_frame_in,
    input  logic                  i_frame_we,
    output logic                  o_frame_pending,
    output logic                  o_frame_done,
    output logic                  o_sr_data,
    output logic                  o_sr_clk,
    output logic                  o_sr_latch,
    output logic                  o_sr_oe_n
);

    localparam int C_PHASE_W = $clog2(max_int(CLK_DIV, DWELL) + 1);
    localparam logic [C_PHASE_W-1:0] C_DWELL_RELOAD = C_PHASE_W'(DWELL - 1);

    // Top-level view of the scan: SHIFT_LO stands for "serializer busy"
    // (shift and latch), the finer phases live inside the serializer.
    scan_state_t           r_state,   w_state_nxt;
    logic [2:0]            r_row,     w_row_nxt;
    logic [C_PHASE_W-1:0]  r_dwell,   w_dwell_nxt;
    logic [MX_FRAME_W-1:0] r_active,  w_active_nxt;
    logic [MX_FRAME_W-1:0] r_shadow,  w_shadow_nxt;
    logic                  r_pending, w_pending_nxt;
    logic                  r_oe_n,    w_oe_n_nxt;

    logic                  w_swap;
    logic [MX_FRAME_W-1:0] w_active_view;
    logic [MX_COLS-1:0]    w_row_onehot, w_row_byte, w_col_byte;
    logic [SR_BITS-1:0]    w_word;
    logic                  w_start, w_ser_done;

    // Swap only at the row-0 load; the word for that row must already see the
    // new frame, hence the bypass view.
    assign w_swap        = (r_state == LOAD) && (r_row == 3'd0) && r_pending;
    assign w_active_view = w_swap ? r_shadow : r_active;
    assign w_row_onehot  = 8'd1 << r_row;
    assign w_row_byte    = (ROW_ACTIVE_LOW != 0) ? ~w_row_onehot : w_row_onehot;
    assign w_col_byte    = (COL_ACTIVE_LOW != 0) ? ~w_active_view[{r_row, 3'b000} +: 8]
                                                 :  w_active_view[{r_row, 3'b000} +: 8];
    assign w_word        = {w_row_byte, w_col_byte};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= LOAD;
            r_row     <= '0;
            r_dwell   <= '0;
            r_active  <= '0;
            r_shadow  <= '0;
            r_pending <= 1'b0;
            r_oe_n    <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_row     <= w_row_nxt;
            r_dwell   <= w_dwell_nxt;
            r_active  <= w_active_nxt;
            r_shadow  <= w_shadow_nxt;
            r_pending <= w_pending_nxt;
            r_oe_n    <= w_oe_n_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_row_nxt     = r_row;
        w_dwell_nxt   = r_dwell;
        w_active_nxt  = r_active;
        w_shadow_nxt  = r_shadow;
        w_pending_nxt = r_pending;
        w_oe_n_nxt    = r_oe_n;
        w_start       = 1'b0;
        o_frame_done  = 1'b0;

        if (i_frame_we) begin
            w_shadow_nxt  = i_frame_in;
            w_pending_nxt = 1'b1;
        end

        case (r_state)
            LOAD: begin
                w_start     = 1'b1;
                w_state_nxt = SHIFT_LO;
                if (w_swap) begin
                    w_active_nxt = r_shadow;
                    // A write landing in the swap cycle is a fresh pending frame.
                    if (!i_frame_we) begin
                        w_pending_nxt = 1'b0;
                    end
                end
            end
            SHIFT_LO: begin
                if (w_ser_done) begin
                    w_dwell_nxt = C_DWELL_RELOAD;
                    w_oe_n_nxt  = 1'b0;
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (r_dwell == '0) begin
                    w_row_nxt    = r_row + 3'd1;
                    w_state_nxt  = LOAD;
                    o_frame_done = (r_row == 3'd7);
                end else begin
                    w_dwell_nxt = r_dwell - C_PHASE_W'(1);
                end
            end
            default: w_state_nxt = LOAD;
        endcase
    end

    sr595_serializer #(
        .CLK_DIV (CLK_DIV),
        .PHASE_W (C_PHASE_W)
    ) u_ser (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (w_start),
        .i_word     (w_word),
        .o_done     (w_ser_done),
        .o_sr_data  (o_sr_data),
        .o_sr_clk   (o_sr_clk),
        .o_sr_latch (o_sr_latch)
    );

    assign o_frame_pending = r_pending;
    assign o_sr_oe_n       = r_oe_n;

endmodule
`default_nettype wire

// File: tb/tb_matrix_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_matrix_scan_driver
//  Purpose  : Bench for two matrix_scan_driver instances (different divider,
//             dwell and polarities) against a schedule-based frame model and
//             a pair of modelled 74HC595 chains.
//  Revision : 1.0  initial release
// ============================================================================
module tb_matrix_scan_driver;

    localparam int CD_A = 1, DW_A = 4, P_A = 1 + 33*CD_A + DW_A;   // 38
    localparam int CD_B = 2, DW_B = 3, P_B = 1 + 33*CD_B + DW_B;   // 70

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] frame_in;
    logic        frame_we;

    logic a_pend, a_done, a_data, a_clk, a_lat, a_oe;
    logic b_pend, b_done, b_data, b_clk, b_lat, b_oe;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Frame model: per instance, cycles since reset release, buffers, word in flight.
    int          m_n[2];
    logic [63:0] m_act[2];
    logic [63:0] m_sh[2];
    logic        m_pend[2];
    logic [15:0] m_word[2];

    // '595 chain models
    logic [15:0] sreg[2];
    logic [15:0] lat_rows[2][8];
    int          latcnt[2];
    int          clkcnt[2];
    int          nclk[2];
    int          gap[2];
    int          last_lat[2];
    int          done_cnt_a = 0;

    always #5 clk = ~clk;

    matrix_scan_driver #(.CLK_DIV(CD_A), .DWELL(DW_A), .ROW_ACTIVE_LOW(1), .COL_ACTIVE_LOW(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .i_frame_in(frame_in), .i_frame_we(frame_we),
        .o_frame_pending(a_pend), .o_frame_done(a_done), .o_sr_data(a_data),
        .o_sr_clk(a_clk), .o_sr_latch(a_lat), .o_sr_oe_n(a_oe));

    matrix_scan_driver #(.CLK_DIV(CD_B), .DWELL(DW_B), .ROW_ACTIVE_LOW(0), .COL_ACTIVE_LOW(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .i_frame_in(frame_in), .i_frame_we(frame_we),
        .o_frame_pending(b_pend), .o_frame_done(b_done), .o_sr_data(b_data),
        .o_sr_clk(b_clk), .o_sr_latch(b_lat), .o_sr_oe_n(b_oe));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] mk_word(input int i, input int row, input logic [63:0] fr);
        logic [7:0] oh, rb, cb;
        oh = 8'd1 << row;
        rb = (i == 0) ? ~oh : oh;
        cb = fr[row*8 +: 8];
        if (i == 1) cb = ~cb;
        return {rb, cb};
    endfunction

    // Expected {data, clk, latch, done, oe_n, pending} from the row schedule.
    function automatic logic [5:0] exp_out(input int i);
        int cd, p, o, row, j;
        logic d, c, l, dn, oe;
        if (!rst_n) return 6'b000010;
        cd  = (i == 0) ? CD_A : CD_B;
        p   = (i == 0) ? P_A : P_B;
        o   = m_n[i] % p;
        row = (m_n[i] / p) % 8;
        d = 1'b0; c = 1'b0;
        if (o >= 1 && o <= 32*cd) begin
            j = (o - 1) / (2*cd);
            c = ((o - 1) % (2*cd)) >= cd;
            d = m_word[i][15-j];
        end
        l  = (o > 32*cd) && (o <= 33*cd);
        dn = (o == p - 1) && (row == 7);
        oe = m_n[i] < 1 + 33*cd;
        return {d, c, l, dn, oe, m_pend[i]};
    endfunction

    always @(posedge clk) cyc++;

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_n[i] = 0; m_act[i] = '0; m_sh[i] = '0; m_pend[i] = 1'b0; m_word[i] = '0;
            end else begin
                int p, o, row;
                p   = (i == 0) ? P_A : P_B;
                o   = m_n[i] % p;
                row = (m_n[i] / p) % 8;
                if (o == 0) begin
                    if (row == 0 && m_pend[i]) begin
                        m_act[i]  = m_sh[i];
                        m_pend[i] = 1'b0;
                    end
                    m_word[i] = mk_word(i, row, m_act[i]);
                end
                if (frame_we) begin
                    m_sh[i]   = frame_in;
                    m_pend[i] = 1'b1;
                end
                m_n[i]++;
            end
        end
    end

    // Per-cycle compare of every output of both instances.
    always @(negedge clk) begin
        check($sformatf("outs_a n=%0d", m_n[0]), {58'd0, a_data, a_clk, a_lat, a_done, a_oe, a_pend}, {58'd0, exp_out(0)});
        check($sformatf("outs_b n=%0d", m_n[1]), {58'd0, b_data, b_clk, b_lat, b_done, b_oe, b_pend}, {58'd0, exp_out(1)});
        if (rst_n && a_done) done_cnt_a++;
    end

    always @(posedge a_clk) begin sreg[0] = {sreg[0][14:0], a_data}; clkcnt[0]++; end
    always @(posedge b_clk) begin sreg[1] = {sreg[1][14:0], b_data}; clkcnt[1]++; end

    always @(posedge a_lat) begin
        lat_rows[0][(m_n[0] / P_A) % 8] = sreg[0];
        latcnt[0]++; gap[0] = cyc - last_lat[0]; last_lat[0] = cyc; nclk[0] = clkcnt[0]; clkcnt[0] = 0;
        check("latched_a", {48'd0, sreg[0]}, {48'd0, m_word[0]});
    end
    always @(posedge b_lat) begin
        lat_rows[1][(m_n[1] / P_B) % 8] = sreg[1];
        latcnt[1]++; gap[1] = cyc - last_lat[1]; last_lat[1] = cyc; nclk[1] = clkcnt[1]; clkcnt[1] = 0;
        check("latched_b", {48'd0, sreg[1]}, {48'd0, m_word[1]});
    end

    task automatic write_frame(input logic [63:0] v);
        frame_in = v;
        frame_we = 1'b1;
        @(negedge clk);
        frame_we = 1'b0;
    endtask

    task automatic wait_pos(input int i, input int row, input int off);
        int p;
        p = (i == 0) ? P_A : P_B;
        for (int k = 0; k < 3*8*p; k++) begin
            @(negedge clk);
            if ((m_n[i] % p) == off && ((m_n[i] / p) % 8) == row) return;
        end
        check("wait_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_full_frame(input int i);
        int p;
        p = (i == 0) ? P_A : P_B;
        wait_pos(i, 7, p - 1);
        wait_pos(i, 7, p - 1);
    endtask

    initial begin
        logic [63:0] fa, fb, fc, fd;
        int lc, dc;
        for (int i = 0; i < 2; i++) begin
            sreg[i] = '0; latcnt[i] = 0; clkcnt[i] = 0; nclk[i] = 0; gap[i] = 0; last_lat[i] = 0;
        end
        rst_n = 1'b0; frame_we = 1'b0; frame_in = '0;
        repeat (3) @(negedge clk);
        check("reset_outs_a", {58'd0, a_data, a_clk, a_lat, a_done, a_oe, a_pend}, 64'b000010);
        #1 rst_n = 1'b1;

        // Single pixel at (0,0)
        @(negedge clk);
        write_frame(64'h0000_0000_0000_0001);
        wait_full_frame(0);
        check("row0_word_a", {48'd0, lat_rows[0][0]}, 64'hFE01);
        check("row1_word_a", {48'd0, lat_rows[0][1]}, 64'hFD00);
        check("row_period_a", 64'(gap[0]), 64'd38);
        check("srclk_per_row_a", 64'(nclk[0]), 64'd16);
        wait_full_frame(1);
        check("row0_word_b", {48'd0, lat_rows[1][0]}, 64'h01FE);
        check("row_period_b", 64'(gap[1]), 64'd70);

        // Diagonal
        write_frame(64'h8040_2010_0804_0201);
        wait_full_frame(0);
        for (int r = 0; r < 8; r++) begin
            logic [7:0] oh;
            oh = 8'd1 << r;
            check($sformatf("diag_a row%0d", r), {48'd0, lat_rows[0][r]}, {48'd0, ~oh, oh});
        end
        wait_full_frame(1);
        for (int r = 0; r < 8; r++) begin
            logic [7:0] oh;
            oh = 8'd1 << r;
            check($sformatf("diag_b row%0d", r), {48'd0, lat_rows[1][r]}, {48'd0, oh, ~oh});
        end

        // Frame A, then B written during row 3
        fa = 64'h0123_4567_89AB_CDEF;
        fb = 64'hFEDC_BA98_7654_3210;
        write_frame(fa);
        wait_full_frame(0);
        wait_pos(0, 3, 5);
        write_frame(fb);
        check("pend_after_B", {63'd0, a_pend}, 64'd1);
        wait_pos(0, 7, P_A - 1);
        check("row3_still_A", {56'd0, lat_rows[0][3][7:0]}, 64'h89);
        check("row7_still_A", {56'd0, lat_rows[0][7][7:0]}, 64'h01);
        check("pend_before_swap", {63'd0, a_pend}, 64'd1);
        wait_pos(0, 0, 5);
        check("pend_after_swap", {63'd0, a_pend}, 64'd0);
        wait_pos(0, 0, P_A - 1);
        check("row0_shows_B", {56'd0, lat_rows[0][0][7:0]}, 64'h10);

        // Write in the same cycle as the row-0 load
        fc = 64'h1111_2222_3333_4444;
        fd = 64'h5555_6666_7777_8888;
        wait_pos(0, 2, 5);
        write_frame(fc);
        wait_pos(0, 0, 0);
        write_frame(fd);
        check("pend_same_cycle", {63'd0, a_pend}, 64'd1);
        wait_pos(0, 0, P_A - 1);
        check("row0_prev_shadow", {56'd0, lat_rows[0][0][7:0]}, 64'h44);
        wait_full_frame(0);
        check("row0_next_frame", {56'd0, lat_rows[0][0][7:0]}, 64'h88);
        check("pend_cleared", {63'd0, a_pend}, 64'd0);

        // Reset during bit_idx 7 of row 5
        wait_pos(0, 5, 1 + 16*CD_A);
        lc = latcnt[0];
        #2 rst_n = 1'b0;
        #1;
        check("midreset_outs_a", {58'd0, a_data, a_clk, a_lat, a_done, a_oe, a_pend}, 64'b000010);
        check("midreset_outs_b", {58'd0, b_data, b_clk, b_lat, b_done, b_oe, b_pend}, 64'b000010);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        check("no_latch_in_reset", 64'(latcnt[0]), 64'(lc));
        wait_pos(0, 0, P_A - 1);
        check("blank_after_reset", {48'd0, lat_rows[0][0]}, 64'hFE00);
        check("one_latch_after_reset", 64'(latcnt[0]), 64'(lc + 1));

        // All-ones frame
        write_frame({64{1'b1}});
        wait_full_frame(1);
        for (int r = 0; r < 8; r++) begin
            logic [7:0] oh;
            oh = 8'd1 << r;
            check($sformatf("ones_b row%0d", r), {48'd0, lat_rows[1][r]}, {48'd0, oh, 8'h00});
        end
        dc = done_cnt_a;
        repeat (8*P_A) @(negedge clk);
        check("frame_done_per_frame", 64'(done_cnt_a - dc), 64'd1);

        // Random frames at random times, sometimes back-to-back
        for (int k = 0; k < 10; k++) begin
            repeat ($urandom_range(1, 400)) @(negedge clk);
            write_frame({$urandom, $urandom});
            if ($urandom_range(0, 3) == 0) write_frame({$urandom, $urandom});
        end
        wait_full_frame(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
